// File: rtl/motor_pkg.sv
// rtl/motor_pkg.sv - shared types and constants for the motor command ramp
// Purpose: duty width, duty ceiling, per-channel FSM states, command struct,
//          and the duty clamp helper used when a new target is loaded.
// Ports:   none (package)
package motor_pkg;

  localparam int DUTY_W   = 7;
  localparam int MAX_DUTY = 100;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    RAMP  = 2'd1,
    BRAKE = 2'd2,
    DEAD  = 2'd3
  } ramp_state_t;

  typedef struct packed {
    logic              dir;
    logic [DUTY_W-1:0] duty;
  } motor_cmd_t;

  function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] duty,
                                                   input logic [DUTY_W-1:0] limit);
    return (duty > limit) ? limit : duty;
  endfunction

endpackage

// File: rtl/motor_cmd_ramp_if.sv
// rtl/motor_cmd_ramp_if.sv - command in / applied drive out bundle
// Purpose: groups the command pair from the SPI receiver and the conditioned
//          drive toward the PWM stage.
// Ports:   master drives cmd_*, reads out_*/ramping/wdog_trip;
//          slave (the ramp block) is the mirror image.
interface motor_cmd_ramp_if;
  import motor_pkg::*;

  logic              cmd_valid;
  logic              cmd_dir1;
  logic [DUTY_W-1:0] cmd_duty1;
  logic              cmd_dir2;
  logic [DUTY_W-1:0] cmd_duty2;
  logic              out_dir1;
  logic [DUTY_W-1:0] out_duty1;
  logic              out_dir2;
  logic [DUTY_W-1:0] out_duty2;
  logic              ramping;
  logic              wdog_trip;

  modport master (
    output cmd_valid, cmd_dir1, cmd_duty1, cmd_dir2, cmd_duty2,
    input  out_dir1, out_duty1, out_dir2, out_duty2, ramping, wdog_trip
  );

  modport slave (
    input  cmd_valid, cmd_dir1, cmd_duty1, cmd_dir2, cmd_duty2,
    output out_dir1, out_duty1, out_dir2, out_duty2, ramping, wdog_trip
  );

endinterface

// File: rtl/motor_ramp_channel.sv
// rtl/motor_ramp_channel.sv - one motor channel: target regs, slew FSM, dead time
// Purpose: slews out_duty toward the target one STEP per tick, brakes to zero and
//          waits DEADTIME cycles before any direction reversal.
// Ports:   clk, reset (sync, active-high), tick (shared ramp tick),
//          load/cmd (new target), wdog_zero (force target duty to 0),
//          out_dir/out_duty (applied drive), busy (state != HOLD).
module motor_ramp_channel
  import motor_pkg::*;
#(
  parameter int MAX_DUTY = motor_pkg::MAX_DUTY,
  parameter int STEP     = 1,
  parameter int DEADTIME = 590
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              load,
  input  motor_cmd_t        cmd,
  input  logic              wdog_zero,
  output logic              out_dir,
  output logic [DUTY_W-1:0] out_duty,
  output logic              busy
);

  localparam int                CW        = $clog2(DEADTIME + 1);
  localparam logic [DUTY_W:0]   STEP_X    = (DUTY_W + 1)'(STEP);
  localparam logic [DUTY_W-1:0] STEP_D    = DUTY_W'(STEP);
  localparam logic [DUTY_W-1:0] MAX_D     = DUTY_W'(MAX_DUTY);
  localparam logic [CW-1:0]     DEAD_LOAD = CW'(DEADTIME - 1);

  ramp_state_t       state;
  logic              tgt_dir;
  logic [DUTY_W-1:0] tgt_duty;
  logic [CW-1:0]     dead_cnt;

  logic [DUTY_W:0]   cur_x, tgt_x, up_x;
  logic [DUTY_W-1:0] dn_d, ramp_next, brake_next;
  logic              flip;

  // Step arithmetic is one bit wider so neither 0-STEP nor 127+STEP wraps.
  always_comb begin
    cur_x = {1'b0, out_duty};
    tgt_x = {1'b0, tgt_duty};
    up_x  = cur_x + STEP_X;
    dn_d  = out_duty - STEP_D;
    if (cur_x < tgt_x)
      ramp_next = (up_x >= tgt_x) ? tgt_duty : up_x[DUTY_W-1:0];
    else
      ramp_next = (cur_x <= tgt_x + STEP_X) ? tgt_duty : dn_d;
    brake_next = (cur_x <= STEP_X) ? '0 : dn_d;
    // A reversal toward duty 0 is no reversal: keep direction, just slow down.
    flip = (tgt_dir != out_dir) && (tgt_duty != '0);
  end

  assign busy = (state != HOLD);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= HOLD;
      tgt_dir  <= 1'b0;
      tgt_duty <= '0;
      dead_cnt <= '0;
      out_dir  <= 1'b0;
      out_duty <= '0;
    end else begin
      // A command in the same cycle as watchdog expiry takes precedence.
      if (load) begin
        tgt_dir  <= cmd.dir;
        tgt_duty <= clamp_duty(cmd.duty, MAX_D);
      end else if (wdog_zero) begin
        tgt_duty <= '0;
      end

      case (state)
        HOLD: begin
          if (flip) begin
            if (out_duty == '0) begin
              state    <= DEAD;
              dead_cnt <= DEAD_LOAD;
            end else begin
              state <= BRAKE;
            end
          end else if (out_duty != tgt_duty) begin
            state <= RAMP;
          end
        end
        RAMP: begin
          if (flip) begin
            if (out_duty == '0) begin
              state    <= DEAD;
              dead_cnt <= DEAD_LOAD;
            end else begin
              state <= BRAKE;
            end
          end else if (out_duty == tgt_duty) begin
            state <= HOLD;
          end else if (tick) begin
            out_duty <= ramp_next;
            if (ramp_next == tgt_duty) state <= HOLD;
          end
        end
        BRAKE: begin
          if (!flip) begin
            state <= RAMP;
          end else if (out_duty == '0) begin
            state    <= DEAD;
            dead_cnt <= DEAD_LOAD;
          end else if (tick) begin
            out_duty <= brake_next;
            if (brake_next == '0) begin
              state    <= DEAD;
              dead_cnt <= DEAD_LOAD;
            end
          end
        end
        DEAD: begin
          // Duty stays 0; target changes just accumulate until the wait ends.
          if (dead_cnt == '0) begin
            out_dir <= tgt_dir;
            state   <= (tgt_duty == '0) ? HOLD : RAMP;
          end else begin
            dead_cnt <= dead_cnt - 1'b1;
          end
        end
        default: state <= HOLD;
      endcase
    end
  end

endmodule

// File: rtl/motor_cmd_ramp.sv
// rtl/motor_cmd_ramp.sv - two-channel motor command slew / dead-time / watchdog
// Purpose: conditions the SPI command pair before the PWM stage; holds the shared
//          ramp prescaler, the command watchdog and the ramping flag.
// Ports:   clk, reset (sync, active-high), bus (motor_cmd_ramp_if.slave:
//          cmd_valid/cmd_dir*/cmd_duty* in, out_dir*/out_duty*/ramping/wdog_trip out).
module motor_cmd_ramp
  import motor_pkg::*;
#(
  parameter int MAX_DUTY   = motor_pkg::MAX_DUTY,
  parameter int STEP       = 1,
  parameter int RAMP_DIV   = 59,
  parameter int DEADTIME   = 590,
  parameter int WDOG_TICKS = 500
) (
  input  logic             clk,
  input  logic             reset,
  motor_cmd_ramp_if.slave  bus
);

  localparam int PW = $clog2(RAMP_DIV + 1);
  localparam int WW = $clog2(WDOG_TICKS + 1);

  logic [PW-1:0] pre_cnt;
  logic [WW-1:0] wdog_cnt;
  logic          tick;
  logic          wdog_fire;
  logic          busy1, busy2;
  motor_cmd_t    cmd1, cmd2;

  assign tick      = (pre_cnt == PW'(RAMP_DIV - 1));
  // The counter saturates at WDOG_TICKS, so expiry fires exactly once per silence.
  assign wdog_fire = tick && !bus.cmd_valid && (wdog_cnt == WW'(WDOG_TICKS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt       <= '0;
      wdog_cnt      <= '0;
      bus.wdog_trip <= 1'b0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      if (bus.cmd_valid) begin
        wdog_cnt      <= '0;
        bus.wdog_trip <= 1'b0;
      end else if (tick && (wdog_cnt != WW'(WDOG_TICKS))) begin
        wdog_cnt <= wdog_cnt + 1'b1;
      end
      if (wdog_fire) bus.wdog_trip <= 1'b1;
    end
  end

  assign cmd1 = '{dir: bus.cmd_dir1, duty: bus.cmd_duty1};
  assign cmd2 = '{dir: bus.cmd_dir2, duty: bus.cmd_duty2};

  motor_ramp_channel #(.MAX_DUTY(MAX_DUTY), .STEP(STEP), .DEADTIME(DEADTIME)) u_ch1 (
    .clk(clk), .reset(reset), .tick(tick), .load(bus.cmd_valid), .cmd(cmd1),
    .wdog_zero(wdog_fire), .out_dir(bus.out_dir1), .out_duty(bus.out_duty1), .busy(busy1)
  );

  motor_ramp_channel #(.MAX_DUTY(MAX_DUTY), .STEP(STEP), .DEADTIME(DEADTIME)) u_ch2 (
    .clk(clk), .reset(reset), .tick(tick), .load(bus.cmd_valid), .cmd(cmd2),
    .wdog_zero(wdog_fire), .out_dir(bus.out_dir2), .out_duty(bus.out_duty2), .busy(busy2)
  );

  // Decoded straight from the two state registers.
  assign bus.ramping = busy1 | busy2;

endmodule

// File: tb/tb_motor_cmd_ramp.sv
// tb/tb_motor_cmd_ramp.sv - directed bench for motor_cmd_ramp
module tb_motor_cmd_ramp;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  bit   keepalive = 0;
  int   ka = 0;

  always #5 clk = ~clk;

  motor_cmd_ramp_if bus ();

  motor_cmd_ramp #(.RAMP_DIV(4), .DEADTIME(8), .WDOG_TICKS(50), .STEP(1)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  // One clock; sample point is 1 ns after the edge. Keepalive re-sends the
  // held command every 40 cycles so long ramps do not trip the watchdog.
  task automatic cyc();
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    if (keepalive) begin
      ka++;
      if (ka >= 40) begin
        ka = 0;
        bus.cmd_valid = 1'b1;
      end
    end
  endtask

  task automatic send(input logic d1, input int u1, input logic d2, input int u2);
    bus.cmd_dir1  = d1;
    bus.cmd_duty1 = 7'(u1);
    bus.cmd_dir2  = d2;
    bus.cmd_duty2 = 7'(u2);
    bus.cmd_valid = 1'b1;
    ka = 0;
    cyc();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    checks++; if (bus.out_duty1 !== 7'd0) begin errors++; $display("FAIL reset_duty1 got=%0d exp=0", bus.out_duty1); end
    checks++; if (bus.out_duty2 !== 7'd0) begin errors++; $display("FAIL reset_duty2 got=%0d exp=0", bus.out_duty2); end
    checks++; if (bus.out_dir1 !== 1'b0 || bus.out_dir2 !== 1'b0) begin errors++; $display("FAIL reset_dir got=%b%b exp=00", bus.out_dir1, bus.out_dir2); end
    checks++; if (bus.ramping !== 1'b0 || bus.wdog_trip !== 1'b0) begin errors++; $display("FAIL reset_flags ramping=%b wdog=%b exp=0 0", bus.ramping, bus.wdog_trip); end
  endtask

  task automatic test_ramp_up();
    int last = -1;
    int steps = 0;
    int prev = 0;
    int cur;
    send(1'b0, 20, 1'b0, 0);
    for (int n = 1; n <= 200; n++) begin
      cyc();
      cur = int'(bus.out_duty1);
      if (cur != prev) begin
        checks++; if (cur != prev + 1) begin errors++; $display("FAIL ramp_step got=%0d exp=%0d", cur, prev + 1); end
        if (last >= 0) begin
          checks++; if (n - last != 4) begin errors++; $display("FAIL ramp_spacing got=%0d exp=4", n - last); end
        end
        last = n; steps++; prev = cur;
      end
      if (cur == 20) break;
      checks++; if (bus.ramping !== 1'b1) begin errors++; $display("FAIL ramp_busy duty=%0d got=%b exp=1", cur, bus.ramping); end
    end
    checks++; if (bus.out_duty1 !== 7'd20) begin errors++; $display("FAIL ramp_final got=%0d exp=20", bus.out_duty1); end
    checks++; if (bus.ramping !== 1'b0) begin errors++; $display("FAIL ramp_done_busy got=%b exp=0", bus.ramping); end
    checks++; if (steps != 20) begin errors++; $display("FAIL ramp_steps got=%0d exp=20", steps); end
  endtask

  task automatic test_clamp();
    int peak = 0;
    keepalive = 1;
    send(1'b0, 127, 1'b0, 0);
    for (int n = 0; n < 2000; n++) begin
      cyc();
      if (int'(bus.out_duty1) > peak) peak = int'(bus.out_duty1);
      if (bus.out_duty1 == 7'd100 && !bus.ramping) break;
    end
    for (int n = 0; n < 20; n++) begin
      cyc();
      if (int'(bus.out_duty1) > peak) peak = int'(bus.out_duty1);
    end
    checks++; if (bus.out_duty1 !== 7'd100) begin errors++; $display("FAIL clamp_final got=%0d exp=100", bus.out_duty1); end
    checks++; if (peak != 100) begin errors++; $display("FAIL clamp_peak got=%0d exp=100", peak); end
  endtask

  task automatic test_reversal();
    int zero_at = -1;
    int flip_at = -1;
    logic pdir;
    int pduty;
    send(1'b0, 10, 1'b0, 0);
    for (int n = 0; n < 2000; n++) begin
      cyc();
      if (bus.out_duty1 == 7'd10 && !bus.ramping) break;
    end
    checks++; if (bus.out_duty1 !== 7'd10 || bus.out_dir1 !== 1'b0) begin errors++; $display("FAIL rev_start got=%b/%0d exp=0/10", bus.out_dir1, bus.out_duty1); end
    pdir = bus.out_dir1; pduty = int'(bus.out_duty1);
    send(1'b1, 10, 1'b0, 0);
    for (int n = 1; n <= 500; n++) begin
      if (bus.out_duty1 == 7'd0 && zero_at < 0) zero_at = n;
      if (bus.out_dir1 !== pdir) begin
        flip_at = n;
        checks++; if (pduty != 0 || bus.out_duty1 !== 7'd0) begin errors++; $display("FAIL rev_flip_duty got=%0d/%0d exp=0/0", pduty, bus.out_duty1); end
      end
      pdir = bus.out_dir1; pduty = int'(bus.out_duty1);
      if (bus.out_dir1 == 1'b1 && bus.out_duty1 == 7'd10 && !bus.ramping) break;
      cyc();
    end
    checks++; if (flip_at - zero_at != 8) begin errors++; $display("FAIL rev_deadtime got=%0d exp=8", flip_at - zero_at); end
    checks++; if (bus.out_dir1 !== 1'b1 || bus.out_duty1 !== 7'd10) begin errors++; $display("FAIL rev_final got=%b/%0d exp=1/10", bus.out_dir1, bus.out_duty1); end
  endtask

  task automatic test_brake_abort();
    bit bad = 0;
    send(1'b0, 10, 1'b0, 0);
    for (int n = 0; n < 100; n++) begin
      cyc();
      if (bus.out_duty1 <= 7'd7) break;
    end
    checks++; if (bus.out_duty1 !== 7'd7 || bus.out_dir1 !== 1'b1) begin errors++; $display("FAIL abort_brake got=%b/%0d exp=1/7", bus.out_dir1, bus.out_duty1); end
    send(1'b1, 15, 1'b0, 0);
    for (int n = 0; n < 500; n++) begin
      if (bus.out_dir1 !== 1'b1 || bus.out_duty1 == 7'd0) bad = 1;
      if (bus.out_duty1 == 7'd15 && !bus.ramping) break;
      cyc();
    end
    checks++; if (bad) begin errors++; $display("FAIL abort_no_dead got=flip_or_zero exp=none"); end
    checks++; if (bus.out_duty1 !== 7'd15 || bus.out_dir1 !== 1'b1) begin errors++; $display("FAIL abort_final got=%b/%0d exp=1/15", bus.out_dir1, bus.out_duty1); end
  endtask

  task automatic test_watchdog();
    bit early = 0;
    send(1'b1, 30, 1'b0, 30);
    for (int n = 0; n < 2000; n++) begin
      cyc();
      if (bus.out_duty1 == 7'd30 && bus.out_duty2 == 7'd30 && !bus.ramping) break;
    end
    checks++; if (bus.out_duty1 !== 7'd30 || bus.out_duty2 !== 7'd30) begin errors++; $display("FAIL wd_hold got=%0d/%0d exp=30/30", bus.out_duty1, bus.out_duty2); end
    keepalive = 0;
    send(1'b1, 30, 1'b0, 30);
    for (int n = 1; n <= 196; n++) begin
      cyc();
      if (bus.wdog_trip) early = 1;
    end
    checks++; if (early) begin errors++; $display("FAIL wd_early got=1 exp=0 before tick 50"); end
    for (int n = 0; n < 4; n++) cyc();
    checks++; if (bus.wdog_trip !== 1'b1) begin errors++; $display("FAIL wd_trip got=%b exp=1", bus.wdog_trip); end
    for (int n = 0; n < 400; n++) begin
      cyc();
      if (bus.out_duty1 == 7'd0 && bus.out_duty2 == 7'd0 && !bus.ramping) break;
    end
    checks++; if (bus.out_duty1 !== 7'd0 || bus.out_duty2 !== 7'd0) begin errors++; $display("FAIL wd_zero got=%0d/%0d exp=0/0", bus.out_duty1, bus.out_duty2); end
    checks++; if (bus.out_dir1 !== 1'b1 || bus.out_dir2 !== 1'b0) begin errors++; $display("FAIL wd_dirs got=%b%b exp=10", bus.out_dir1, bus.out_dir2); end
    checks++; if (bus.wdog_trip !== 1'b1) begin errors++; $display("FAIL wd_sticky got=%b exp=1", bus.wdog_trip); end
    keepalive = 1;
    send(1'b1, 5, 1'b0, 5);
    checks++; if (bus.wdog_trip !== 1'b0) begin errors++; $display("FAIL wd_clear got=%b exp=0", bus.wdog_trip); end
  endtask

  task automatic test_reset_mid_ramp();
    send(1'b1, 20, 1'b0, 0);
    for (int n = 0; n < 200; n++) begin
      cyc();
      if (bus.out_duty1 == 7'd7) break;
    end
    checks++; if (bus.out_duty1 !== 7'd7 || bus.ramping !== 1'b1) begin errors++; $display("FAIL mid_setup got=%0d/%b exp=7/1", bus.out_duty1, bus.ramping); end
    keepalive = 0;
    reset = 1'b1;
    cyc();
    checks++; if (bus.out_duty1 !== 7'd0 || bus.out_duty2 !== 7'd0) begin errors++; $display("FAIL mid_duty got=%0d/%0d exp=0/0", bus.out_duty1, bus.out_duty2); end
    checks++; if (bus.out_dir1 !== 1'b0 || bus.ramping !== 1'b0 || bus.wdog_trip !== 1'b0) begin errors++; $display("FAIL mid_flags got=%b%b%b exp=000", bus.out_dir1, bus.ramping, bus.wdog_trip); end
    reset = 1'b0;
    for (int n = 0; n < 10; n++) cyc();
    checks++; if (bus.out_duty1 !== 7'd0 || bus.ramping !== 1'b0) begin errors++; $display("FAIL mid_after got=%0d/%b exp=0/0", bus.out_duty1, bus.ramping); end
  endtask

  initial begin
    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_dir1  = 1'b0;
    bus.cmd_duty1 = 7'd0;
    bus.cmd_dir2  = 1'b0;
    bus.cmd_duty2 = 7'd0;
    test_reset();
    test_ramp_up();
    test_clamp();
    test_reversal();
    test_brake_abort();
    test_watchdog();
    test_reset_mid_ramp();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
